// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM input and MEM/WB output bundle for the MIPS MEM stage
//
// Signals:
//   i_alu_result, i_read_data_2, i_write_register, i_reg_write, i_mem_read,
//   i_mem_write, i_mem_to_reg, i_mem_size, i_mem_unsigned  : EX/MEM side (driven by master)
//   o_stall, o_read_data, o_alu_result, o_write_register, o_reg_write,
//   o_mem_to_reg, o_misaligned                             : MEM/WB side (driven by slave)
// Modports:
//   master : upstream pipeline / environment
//   slave  : mem_stage
interface mem_stage_if;
    logic [31:0] i_alu_result;
    logic [31:0] i_read_data_2;
    logic [4:0]  i_write_register;
    logic        i_reg_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_to_reg;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;

    logic        o_stall;
    logic [31:0] o_read_data;
    logic [31:0] o_alu_result;
    logic [4:0]  o_write_register;
    logic        o_reg_write;
    logic        o_mem_to_reg;
    logic        o_misaligned;

    modport master (
        output i_alu_result, i_read_data_2, i_write_register, i_reg_write,
               i_mem_read, i_mem_write, i_mem_to_reg, i_mem_size, i_mem_unsigned,
        input  o_stall, o_read_data, o_alu_result, o_write_register,
               o_reg_write, o_mem_to_reg, o_misaligned
    );

    modport slave (
        input  i_alu_result, i_read_data_2, i_write_register, i_reg_write,
               i_mem_read, i_mem_write, i_mem_to_reg, i_mem_size, i_mem_unsigned,
        output o_stall, o_read_data, o_alu_result, o_write_register,
               o_reg_write, o_mem_to_reg, o_misaligned
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: byte/half/word data memory access with latency stall and MEM/WB register
//
// Parameters:
//   DEPTH        data memory size in 32-bit words (power of two)
//   ADDR_BITS    log2(DEPTH); word index = i_alu_result[ADDR_BITS+1:2]
//   MEM_LATENCY  cycles per aligned load/store (>=1); 1 means no stall
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   bus          mem_stage_if.slave: EX/MEM inputs, o_stall, MEM/WB outputs
//   i_dbg_addr   (MEM_DEBUG_READ_EN only) debug word index
//   o_dbg_data   (MEM_DEBUG_READ_EN only) word at i_dbg_addr, one cycle later
// Optional feature macro: MEM_DEBUG_READ_EN
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_BITS   = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef MEM_DEBUG_READ_EN
    input  logic [ADDR_BITS-1:0] i_dbg_addr,
    output logic [31:0]          o_dbg_data,
`endif
    mem_stage_if.slave           bus
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;

    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                 req;
    logic                 is_store;
    logic                 is_load;
    logic                 size_byte;
    logic                 size_half;
    logic                 size_word;
    logic                 misaligned;
    logic                 aligned_req;
    logic [1:0]           byte_off;
    logic [ADDR_BITS-1:0] word_idx;

    assign req       = bus.i_mem_read | bus.i_mem_write;
    // A store wins over a simultaneous load request.
    assign is_store  = bus.i_mem_write;
    assign is_load   = bus.i_mem_read & ~bus.i_mem_write;
    assign size_byte = (bus.i_mem_size == 2'b00);
    assign size_half = (bus.i_mem_size == 2'b01);
    // 2'b10 is treated as a word access.
    assign size_word = bus.i_mem_size[1];
    assign byte_off  = bus.i_alu_result[1:0];
    // Upper address bits are dropped, so addresses wrap modulo DEPTH.
    assign word_idx  = bus.i_alu_result[ADDR_BITS+1:2];

    assign misaligned  = req & ((size_half & byte_off[0]) |
                                (size_word & (byte_off != 2'b00)));
    assign aligned_req = req & ~misaligned;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    logic stall;
    logic complete;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // In BUSY the counter is decremented every cycle; the cycle in which the
    // decremented value reaches zero is the completion cycle, so an access
    // spends MEM_LATENCY-1 cycles stalled and completes on the last one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_dec  = cnt_q - 1'b1;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_req && (MEM_LATENCY > 1)) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    stall   = 1'b1;
                end else begin
                    // Non-memory, misaligned and single-cycle accesses
                    // all finish in the cycle they arrive.
                    complete = 1'b1;
                end
            end
            BUSY: begin
                cnt_d = cnt_dec;
                if (cnt_dec != '0) begin
                    stall = 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_stall = stall;

    // ------------------------------------------------------------------
    // Store path: little-endian byte lanes selected by address bits [1:0]
    // ------------------------------------------------------------------
    logic        mem_we;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;

    always_comb begin
        wr_mask = 4'b0000;
        wr_data = bus.i_read_data_2;
        if (size_byte) begin
            wr_mask = 4'b0001 << byte_off;
            wr_data = {4{bus.i_read_data_2[7:0]}};
        end else if (size_half) begin
            wr_mask = byte_off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.i_read_data_2[15:0]}};
        end else begin
            wr_mask = 4'b1111;
        end
    end

    // reset gates the write so an access aborted by reset never commits.
    assign mem_we = reset & complete & is_store & ~misaligned;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: lane select and sign/zero extension
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign rd_word = mem[word_idx];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (byte_off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

        if (size_byte) begin
            rd_ext = {{24{rd_byte[7] & ~bus.i_mem_unsigned}}, rd_byte};
        end else if (size_half) begin
            rd_ext = {{16{rd_half[15] & ~bus.i_mem_unsigned}}, rd_half};
        end else begin
            rd_ext = rd_word;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.o_read_data      <= '0;
            bus.o_alu_result     <= '0;
            bus.o_write_register <= '0;
            bus.o_reg_write      <= 1'b0;
            bus.o_mem_to_reg     <= 1'b0;
            bus.o_misaligned     <= 1'b0;
        end else if (!complete) begin
            // Stalled: hand write-back a bubble.
            bus.o_read_data      <= '0;
            bus.o_alu_result     <= '0;
            bus.o_write_register <= '0;
            bus.o_reg_write      <= 1'b0;
            bus.o_mem_to_reg     <= 1'b0;
            bus.o_misaligned     <= 1'b0;
        end else begin
            bus.o_read_data      <= (is_load && !misaligned) ? rd_ext : 32'h0;
            bus.o_alu_result     <= bus.i_alu_result;
            bus.o_write_register <= bus.i_write_register;
            bus.o_reg_write      <= bus.i_reg_write & ~misaligned;
            bus.o_mem_to_reg     <= bus.i_mem_to_reg;
            bus.o_misaligned     <= misaligned;
        end
    end

`ifdef MEM_DEBUG_READ_EN
    // Read-only side port for the debug unit; independent of the pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage at MEM_LATENCY 1 and 3
module tb_mem_stage;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_stage_if if1 ();
    mem_stage_if if3 ();

`ifdef MEM_DEBUG_READ_EN
    logic [7:0]  dbg_addr1 = 8'h0;
    logic [7:0]  dbg_addr3 = 8'h0;
    logic [31:0] dbg_data1;
    logic [31:0] dbg_data3;
`endif

    mem_stage #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
`ifdef MEM_DEBUG_READ_EN
        .i_dbg_addr (dbg_addr1),
        .o_dbg_data (dbg_data1),
`endif
        .bus        (if1)
    );

    mem_stage #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
`ifdef MEM_DEBUG_READ_EN
        .i_dbg_addr (dbg_addr3),
        .o_dbg_data (dbg_data3),
`endif
        .bus        (if3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drv(input bit s3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wr, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [1:0] sz, input logic uns);
        if (s3) begin
            if3.i_alu_result = addr; if3.i_read_data_2 = wd; if3.i_write_register = wr;
            if3.i_reg_write = rw; if3.i_mem_read = mr; if3.i_mem_write = mw;
            if3.i_mem_to_reg = m2r; if3.i_mem_size = sz; if3.i_mem_unsigned = uns;
        end else begin
            if1.i_alu_result = addr; if1.i_read_data_2 = wd; if1.i_write_register = wr;
            if1.i_reg_write = rw; if1.i_mem_read = mr; if1.i_mem_write = mw;
            if1.i_mem_to_reg = m2r; if1.i_mem_size = sz; if1.i_mem_unsigned = uns;
        end
    endtask

    task automatic st(input bit s3, input logic [31:0] addr, input logic [31:0] d, input logic [1:0] sz);
        drv(s3, addr, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, sz, 1'b0);
    endtask

    task automatic ld(input bit s3, input logic [31:0] addr, input logic [1:0] sz, input logic uns);
        drv(s3, addr, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, sz, uns);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input bit s3, input string tag, input logic e);
        #1;
        chk(tag, {31'h0, s3 ? if3.o_stall : if1.o_stall}, {31'h0, e});
    endtask

    task automatic chk_wb(input bit s3, input string tag, input logic [31:0] rd,
                          input logic rw, input logic mis);
        chk({tag, ".rd"},  s3 ? if3.o_read_data : if1.o_read_data, rd);
        chk({tag, ".rw"},  {31'h0, s3 ? if3.o_reg_write : if1.o_reg_write}, {31'h0, rw});
        chk({tag, ".mis"}, {31'h0, s3 ? if3.o_misaligned : if1.o_misaligned}, {31'h0, mis});
    endtask

    initial begin
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        drv(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        step(); step();
        chk_wb(1'b0, "rst1", 32'h0, 1'b0, 1'b0);
        chk("rst1.alu", if1.o_alu_result, 32'h0);
        chk_wb(1'b1, "rst3", 32'h0, 1'b0, 1'b0);
        chk("rst3.m2r", {31'h0, if3.o_mem_to_reg}, 32'h0);
        reset = 1'b1;

        // ---------------- MEM_LATENCY = 1 ----------------
        st(1'b0, 32'h10, 32'hDEADBEEF, 2'b11); chk_stall(1'b0, "sw10.stall", 1'b0); step();
        ld(1'b0, 32'h10, 2'b11, 1'b0);         chk_stall(1'b0, "lw10.stall", 1'b0); step();
        chk_wb(1'b0, "lw10", 32'hDEADBEEF, 1'b1, 1'b0);
        chk("lw10.wreg", {27'h0, if1.o_write_register}, 32'd7);
        chk("lw10.m2r", {31'h0, if1.o_mem_to_reg}, 32'd1);

        st(1'b0, 32'h10, 32'h0, 2'b11); step();
        st(1'b0, 32'h13, 32'h00000080, 2'b00); step();
        ld(1'b0, 32'h13, 2'b00, 1'b0); step(); chk_wb(1'b0, "lb13",  32'hFFFFFF80, 1'b1, 1'b0);
        ld(1'b0, 32'h13, 2'b00, 1'b1); step(); chk_wb(1'b0, "lbu13", 32'h00000080, 1'b1, 1'b0);
        ld(1'b0, 32'h10, 2'b11, 1'b0); step(); chk_wb(1'b0, "lw10b", 32'h80000000, 1'b1, 1'b0);

        st(1'b0, 32'h20, 32'h11223344, 2'b11); step();
        st(1'b0, 32'h22, 32'h0000BEEF, 2'b01); step();
        ld(1'b0, 32'h22, 2'b01, 1'b0); step(); chk_wb(1'b0, "lh22",  32'hFFFFBEEF, 1'b1, 1'b0);
        ld(1'b0, 32'h22, 2'b01, 1'b1); step(); chk_wb(1'b0, "lhu22", 32'h0000BEEF, 1'b1, 1'b0);
        ld(1'b0, 32'h20, 2'b10, 1'b1); step(); chk_wb(1'b0, "lw20",  32'hBEEF3344, 1'b1, 1'b0);

        // misaligned half store must not touch the word
        st(1'b0, 32'h21, 32'h00005555, 2'b01); chk_stall(1'b0, "sh21.stall", 1'b0); step();
        chk("sh21.mis", {31'h0, if1.o_misaligned}, 32'd1);
        ld(1'b0, 32'h20, 2'b11, 1'b0); step(); chk_wb(1'b0, "lw20b", 32'hBEEF3344, 1'b1, 1'b0);

        // misaligned word load
        ld(1'b0, 32'h11, 2'b11, 1'b0); chk_stall(1'b0, "lw11.stall", 1'b0); step();
        chk_wb(1'b0, "lw11", 32'h0, 1'b0, 1'b1);

        // non-memory pass-through; misaligned flag lasts one slot
        drv(1'b0, 32'h00001234, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0); step();
        chk_wb(1'b0, "add1", 32'h0, 1'b1, 1'b0);
        chk("add1.alu", if1.o_alu_result, 32'h00001234);

        // address wrap: 0x410 aliases word 0x10
        st(1'b0, 32'h410, 32'hA5A5A5A5, 2'b11); step();
        ld(1'b0, 32'h10, 2'b11, 1'b0); step(); chk_wb(1'b0, "wrap", 32'hA5A5A5A5, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // ---------------- MEM_LATENCY = 3 ----------------
        st(1'b1, 32'h40, 32'hCAFEF00D, 2'b11);
        chk_stall(1'b1, "sw40.s0", 1'b1); step(); chk("sw40.b0", {31'h0, if3.o_reg_write}, 32'd0);
        chk_stall(1'b1, "sw40.s1", 1'b1); step(); chk("sw40.b1", {31'h0, if3.o_reg_write}, 32'd0);
        chk_stall(1'b1, "sw40.s2", 1'b0); step();

        ld(1'b1, 32'h10, 2'b11, 1'b0);
        chk_stall(1'b1, "lw3.s0", 1'b1); step(); chk_wb(1'b1, "lw3.b0", 32'h0, 1'b0, 1'b0);
        chk_stall(1'b1, "lw3.s1", 1'b1); step(); chk_wb(1'b1, "lw3.b1", 32'h0, 1'b0, 1'b0);
        chk_stall(1'b1, "lw3.s2", 1'b0);
        // word 0x10 of dut3 was never written; only the timing matters here
        step(); chk("lw3.rw", {31'h0, if3.o_reg_write}, 32'd1);

        drv(1'b1, 32'h00000055, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        chk_stall(1'b1, "add3.stall", 1'b0); step();
        chk("add3.alu", if3.o_alu_result, 32'h00000055);
        chk("add3.rw", {31'h0, if3.o_reg_write}, 32'd1);

        ld(1'b1, 32'h40, 2'b11, 1'b0);
        step(); step();
        chk_stall(1'b1, "lw40.s2", 1'b0); step();
        chk_wb(1'b1, "lw40", 32'hCAFEF00D, 1'b1, 1'b0);

        // reset in the second stall cycle aborts the store
        st(1'b1, 32'h40, 32'h12345678, 2'b11);
        chk_stall(1'b1, "abort.s0", 1'b1); step();
        reset = 1'b0; step();
        chk_wb(1'b1, "abort", 32'h0, 1'b0, 1'b0);
        chk("abort.alu", if3.o_alu_result, 32'h0);
        drv(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        reset = 1'b1; step();

        ld(1'b1, 32'h40, 2'b11, 1'b0);
        chk_stall(1'b1, "lw40b.s0", 1'b1); step();
        chk_stall(1'b1, "lw40b.s1", 1'b1); step();
        chk_stall(1'b1, "lw40b.s2", 1'b0); step();
        chk_wb(1'b1, "lw40b", 32'hCAFEF00D, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage, directly downstream of the execute stage.
- Consumes the execute stage's result, store data, destination register and MEM/WB control bits.
- Performs byte/half/word loads and stores on an internal data memory with a configurable access latency, and stalls upstream while an access is in flight.
- Registers MEM/WB outputs for the write-back stage.

Parameters:
- DEPTH, 256, data memory size in 32-bit words (power of two).
- ADDR_BITS, 8, log2(DEPTH); word index = i_alu_result[ADDR_BITS+1:2].
- MEM_LATENCY, 1, cycles per load/store (>=1); 1 means no stall.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- i_alu_result  in  32  byte address for loads/stores; pass-through value otherwise.
- i_read_data_2  in  32  store data (forwarded rt).
- i_write_register  in  5  destination register.
- i_reg_write  in  1  register write enable.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_mem_to_reg  in  1  WB select: memory (1) or ALU (0).
- i_mem_size  in  2  00 byte, 01 half, 11 word, 10 treated as word.
- i_mem_unsigned  in  1  1 = zero-extend loads (LBU/LHU).
- o_stall  out  1  hold EX/MEM inputs stable; freeze upstream stages.
- o_read_data  out  32  extended load data (MEM/WB).
- o_alu_result  out  32  registered i_alu_result (MEM/WB).
- o_write_register  out  5  MEM/WB destination register.
- o_reg_write  out  1  MEM/WB write enable.
- o_mem_to_reg  out  1  MEM/WB WB select.
- o_misaligned  out  1  one-cycle flag with the faulting instruction's MEM/WB slot.

Behaviour:
- Reset (reset=0 at clk edge): FSM to IDLE, counter 0, all outputs 0. Memory array is not cleared. Reset mid-access aborts the access; the pending store is not committed.
- Request: req = i_mem_read | i_mem_write. If both are set, the store wins and the load is ignored.
- Alignment:
  - half: address bit0 must be 0.
  - word: address bits[1:0] must be 00.
  - byte: always aligned.
- Misaligned request:
  - Completes in 1 cycle regardless of MEM_LATENCY.
  - No memory write; o_read_data=0; o_reg_write=0; o_misaligned=1 for that slot.
- FSM states:
  - IDLE: on an aligned req with MEM_LATENCY=1, complete this cycle. With MEM_LATENCY>1, load counter with MEM_LATENCY-1, go to BUSY, o_stall=1.
  - BUSY: decrement counter each cycle. o_stall=1 while counter!=0. When counter reaches 0 (o_stall=0 that cycle), complete and return to IDLE.
- o_stall is combinational: (IDLE & aligned req & MEM_LATENCY>1) | (BUSY & counter!=0).
- Completion cycle:
  - A store writes memory at this clock edge using byte lanes by address bits[1:0], little-endian. Byte writes lane addr[1:0]; half writes lanes {1,0} or {3,2}.
  - MEM/WB registers capture the inputs plus load data.
- While stalled: MEM/WB registers load a bubble (o_reg_write=0, o_mem_to_reg=0, o_misaligned=0). Upstream must hold inputs stable; changing inputs while o_stall=1 is illegal.
- Non-memory instructions pass through with 1-cycle latency and never stall.
- Load extension:
  - byte/half are sign-extended unless i_mem_unsigned=1.
  - Word ignores i_mem_unsigned.
  - Store-to-load on the following instruction returns the new data; the write commits before the next read.
- Addresses beyond DEPTH wrap modulo DEPTH; address bits above ADDR_BITS+1 are ignored.

Optional Feature:
- Macro MEM_DEBUG_READ_EN.
- Defined: adds ports i_dbg_addr (in, ADDR_BITS, word index) and o_dbg_data (in-module registered, out, 32), the word at i_dbg_addr one cycle later, for the debug unit. The port is read-only and has no effect on stall or pipeline outputs.
- Undefined: the ports are absent and no extra read logic is generated.

Test Plan:
- MEM_LATENCY=1: SW 0xDEADBEEF at 0x10, then LW 0x10 -> next-cycle o_read_data=0xDEADBEEF, o_reg_write=1, o_stall never 1.
- SB 0x80 at 0x13 over word 0x00000000, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
- SH 0xBEEF at 0x22, then LH 0x22 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
- MEM_LATENCY=3, LW 0x10 -> o_stall=1 for 2 cycles with bubble outputs (o_reg_write=0), then data valid; a following ADD result passes through in 1 cycle.
- LW at 0x11 -> o_misaligned=1, o_reg_write=0, o_read_data=0, no stall; SH at 0x21 -> memory word 0x20 unchanged.
- MEM_LATENCY=3, SW 0x12345678 at 0x40, reset=0 asserted in the second stall cycle -> all outputs 0, FSM IDLE; subsequent LW 0x40 returns the old value.
